// File: rtl/signal_decimator_pkg.sv
// Shared constants and helpers for the boxcar accumulate-and-dump decimator.
package signal_decimator_pkg;

    localparam int DEFAULT_ADC_DATA_WIDTH   = 16;
    localparam int DEFAULT_AXIS_TDATA_WIDTH = 32;
    localparam int DEFAULT_MAX_LOG2_DECIM   = 10;

    // The sum of 2^MAX_LOG2_DECIM full-scale samples needs MAX_LOG2_DECIM growth bits.
    localparam int DEFAULT_ACC_WIDTH = DEFAULT_ADC_DATA_WIDTH + DEFAULT_MAX_LOG2_DECIM;

    function automatic logic [3:0] clamp_log2_decim(input logic [3:0] cfg, input int max_k);
        if (int'(cfg) > max_k) begin
            return 4'(max_k);
        end
        return cfg;
    endfunction

endpackage

// File: rtl/signal_decimator_axis_out_reg.sv
// Single-entry AXI-Stream output register with load/hold/drop and a sticky overrun flag.
module axis_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clr_overrun,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              overrun
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              drop;

    // A new result may only replace the held word if it is leaving this cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        drop    = 1'b0;
        if (in_valid) begin
            if (!valid_q || m_tready) begin
                data_d  = in_data;
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (valid_q && m_tready) begin
            valid_d = 1'b0;
        end
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign m_tdata  = data_q;
    assign m_tvalid = valid_q;
    assign overrun  = overrun_q;

endmodule

// File: rtl/signal_decimator.sv
// Boxcar decimator: sums 2^k samples and emits their mean on AXI-Stream.
// Define SIGNAL_DECIMATOR_ROUND_EN for round-half-up instead of truncation.
module signal_decimator
    import signal_decimator_pkg::*;
#(
    parameter int ADC_DATA_WIDTH   = DEFAULT_ADC_DATA_WIDTH,
    parameter int AXIS_TDATA_WIDTH = DEFAULT_AXIS_TDATA_WIDTH,
    parameter int MAX_LOG2_DECIM   = DEFAULT_MAX_LOG2_DECIM
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    input  logic [3:0]                  cfg_log2_decim,
    input  logic                        cfg_clr_overrun,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    output logic                        sts_overrun
);

    localparam int ACC_W = ADC_DATA_WIDTH + MAX_LOG2_DECIM;

    logic signed [ACC_W-1:0]          acc_q, acc_d;
    logic [MAX_LOG2_DECIM-1:0]        cnt_q, cnt_d;
    logic [3:0]                       k_q, k_d;

    logic [3:0]                       k_eff;
    logic [MAX_LOG2_DECIM-1:0]        cnt_mask;
    logic                             last;
    logic signed [ADC_DATA_WIDTH-1:0] sample;
    logic signed [ACC_W-1:0]          x_ext, sum, round_bias, biased;
    logic signed [ADC_DATA_WIDTH-1:0] mean;
    logic [AXIS_TDATA_WIDTH-1:0]      result;
    logic                             res_valid;
    logic                             unused_tdata_hi;

    assign unused_tdata_hi = ^S_AXIS_tdata[AXIS_TDATA_WIDTH-1:ADC_DATA_WIDTH];

    // The first sample of a window already uses the freshly latched ratio.
    always_comb begin
        k_eff    = (cnt_q == '0) ? clamp_log2_decim(cfg_log2_decim, MAX_LOG2_DECIM) : k_q;
        cnt_mask = MAX_LOG2_DECIM'((32'd1 << k_eff) - 32'd1);
        last     = (cnt_q == cnt_mask);
        sample   = S_AXIS_tdata[ADC_DATA_WIDTH-1:0];
        x_ext    = ACC_W'(sample);
        sum      = acc_q + x_ext;
`ifdef SIGNAL_DECIMATOR_ROUND_EN
        round_bias = ACC_W'((32'd1 << k_eff) >> 1);
`else
        round_bias = '0;
`endif
        biased    = sum + round_bias;
        mean      = ADC_DATA_WIDTH'(biased >>> k_eff);
        result    = AXIS_TDATA_WIDTH'(mean);
        res_valid = S_AXIS_tvalid && last;

        acc_d = acc_q;
        cnt_d = cnt_q;
        k_d   = k_q;
        if (S_AXIS_tvalid) begin
            if (cnt_q == '0) begin
                k_d = k_eff;
            end
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + MAX_LOG2_DECIM'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q <= '0;
            cnt_q <= '0;
            k_q   <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            k_q   <= k_d;
        end
    end

    axis_out_reg #(
        .DATA_W (AXIS_TDATA_WIDTH)
    ) u_out_reg (
        .clk         (aclk),
        .rst_n       (aresetn),
        .in_valid    (res_valid),
        .in_data     (result),
        .clr_overrun (cfg_clr_overrun),
        .m_tready    (M_AXIS_tready),
        .m_tdata     (M_AXIS_tdata),
        .m_tvalid    (M_AXIS_tvalid),
        .overrun     (sts_overrun)
    );

endmodule

// File: doc/signal_decimator.md
# signal_decimator

Boxcar accumulate-and-dump decimator placed directly downstream of the ADC signal-split stage. It consumes one sign-extended ADC channel: 32-bit AXI-Stream with tvalid only, where the low ADC_DATA_WIDTH bits carry the sample. It sums 2^k consecutive samples and emits the arithmetic mean as a sign-extended AXI-Stream word with full tvalid/tready handshake. A sticky flag reports results dropped because of downstream back-pressure.

## Interface
- ADC_DATA_WIDTH, 16, significant signed bits of each input word
- AXIS_TDATA_WIDTH, 32, input and output tdata width
- MAX_LOG2_DECIM, 10, largest supported k; accumulator width is ADC_DATA_WIDTH+MAX_LOG2_DECIM
- aclk  in  1  single clock, rising edge
- aresetn  in  1  asynchronous active-low reset
- S_AXIS_tdata  in  AXIS_TDATA_WIDTH  input sample; bits [ADC_DATA_WIDTH-1:0] used, upper bits ignored
- S_AXIS_tvalid  in  1  sample valid; no tready exists, so every valid sample is consumed
- cfg_log2_decim  in  4  k (decimation ratio N = 2^k); values above MAX_LOG2_DECIM clamp to MAX_LOG2_DECIM
- cfg_clr_overrun  in  1  one-cycle pulse that clears sts_overrun
- M_AXIS_tdata  out  AXIS_TDATA_WIDTH  mean value, sign-extended from ADC_DATA_WIDTH
- M_AXIS_tvalid  out  1  output valid
- M_AXIS_tready  in  1  downstream ready
- sts_overrun  out  1  sticky: at least one result was dropped

## Operation
- Registers: accumulator acc (signed, ADC_DATA_WIDTH+MAX_LOG2_DECIM), sample counter cnt (MAX_LOG2_DECIM bits), latched k_q, output register plus valid flag.
- k_q is loaded from the clamped cfg_log2_decim only at a window start (cnt==0 and S_AXIS_tvalid). Configuration changes mid-window take effect at the next window.
- Each valid sample x is sign-extended, and acc <= acc + x. When cnt reaches 2^k_q−1, the window closes: result = (acc + x) >>> k_q (arithmetic shift), acc <= 0, cnt <= 0. Otherwise cnt increments.
- k_q = 0 acts as pass-through: every sample is a result.
- Result is taken from bits [ADC_DATA_WIDTH-1:0] after the shift and sign-extended to AXIS_TDATA_WIDTH. The mean of in-range samples always fits, so no saturation is required.
- Output register, on a new result:
  - If empty, or (M_AXIS_tvalid and M_AXIS_tready) in the same cycle: load the result and keep tvalid high.
  - If full and not M_AXIS_tready: drop the new result, keep the held word, set sts_overrun.
- No new result while M_AXIS_tvalid and M_AXIS_tready: tvalid falls.
- tdata is stable while tvalid is high and tready is low.
- sts_overrun: set has priority over cfg_clr_overrun when both occur in the same cycle.

## Timing
- Reset (async assert, sync deassert assumed upstream): acc=0, cnt=0, k_q=0, M_AXIS_tdata=0, M_AXIS_tvalid=0, sts_overrun=0. Reset mid-window discards the partial sum.
- Latency: M_AXIS_tvalid rises on the clock edge that accepts the window's last sample, so it is visible the cycle after that sample is presented.
- Throughput: one input sample per cycle sustained. At k=0 with tready held high, one output per cycle.
- Gaps in S_AXIS_tvalid pause accumulation and do not reset the window.

## Configuration
- SIGNAL_DECIMATOR_ROUND_EN
  - Defined: for k_q>0, result = (acc + x + 2^(k_q−1)) >>> k_q (round half up). The accumulator width still suffices.
  - Undefined: plain truncation toward −inf.
  - k_q=0 is identical in both builds.

## Structure
- Package signal_decimator_pkg holds:
  - MAX_LOG2_DECIM default
  - accumulator-width localparam formula
  - clamp function for cfg_log2_decim
- Sub-module axis_out_reg holds the single-entry output register: load / hold / drop and overrun-set logic with tvalid/tready. The top level keeps the accumulator, counter and k latch.

## Test plan
- k=0, tready=1, input 0x0000_1234 then 0xFFFF_8000 → outputs 0x0000_1234, 0xFFFF_8000, each one cycle after input.
- k=2, inputs 1,2,3,5 → one output 0x0000_0002 (truncated 11/4). With SIGNAL_DECIMATOR_ROUND_EN: 0x0000_0003.
- k=3, eight samples of −1 (0xFFFF_FFFF) → 0xFFFF_FFFF; eight samples of 0x7FFF → 0x0000_7FFF, no overflow.
- k=0, tready=0, two samples 10, 20 → tdata holds 10, sts_overrun=1. cfg_clr_overrun pulse → sts_overrun=0. tready=1 → 10 accepted, tvalid falls.
- k=2, change cfg_log2_decim to 1 after two samples → window completes at 4 samples, next window uses 2.
- k=2, aresetn low after two samples, then 4 samples of 8 → output 8, with no contribution from the pre-reset samples.
